// File: rtl/trdb_pkg.sv
// Shared trigger codes, FSM state encoding and default widths for the trace
// trigger unit and the encoder filter that consumes its codes.
package trdb_pkg;

    localparam int TRDB_XLEN  = 32;
    localparam int TRDB_CNT_W = 8;

    localparam logic [3:0] TRIG_NONE      = 4'd0;
    localparam logic [3:0] TRIG_TRACE_ON  = 4'd2;
    localparam logic [3:0] TRIG_TRACE_OFF = 4'(3'd3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } trig_state_e;

endpackage

// File: rtl/trdb_addr_cmp.sv
// Valid-qualified full-width equality compare of a retired instruction address
// against a latched reference address.
module trdb_addr_cmp
    import trdb_pkg::*;
#(
    parameter int XLEN = TRDB_XLEN
) (
    input  logic            valid_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] ref_i,
    output logic            match_o
);

    assign match_o = valid_i && (addr_i == ref_i);

endmodule

// File: rtl/trdb_trigger_unit.sv
// Trace trigger unit: counts start-address hits, then sequences trace-on /
// trace-off codes through an IDLE/ARMED/ACTIVE/DONE state machine.
module trdb_trigger_unit
    import trdb_pkg::*;
#(
    parameter int XLEN  = TRDB_XLEN,
    parameter int CNT_W = TRDB_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             trig_enable_i,
    input  logic             trig_oneshot_i,
    input  logic [XLEN-1:0]  start_addr_i,
    input  logic [XLEN-1:0]  stop_addr_i,
    input  logic [CNT_W-1:0] start_count_i,
    input  logic             inst_valid_i,
    input  logic [XLEN-1:0]  iaddr_i,
    output logic [3:0]       trigger_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] hit_count_o
);

    trig_state_e      state_q;
    logic [3:0]       trigger_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [XLEN-1:0]  start_addr_q;
    logic [XLEN-1:0]  stop_addr_q;
    logic [CNT_W-1:0] start_count_q;
    logic             oneshot_q;

    logic             start_hit;
    logic             stop_hit;
    logic [CNT_W:0]   hit_cnt_d;
    logic [CNT_W:0]   threshold;

    trdb_addr_cmp #(.XLEN(XLEN)) u_start_cmp (
        .valid_i (inst_valid_i),
        .addr_i  (iaddr_i),
        .ref_i   (start_addr_q),
        .match_o (start_hit)
    );

    trdb_addr_cmp #(.XLEN(XLEN)) u_stop_cmp (
        .valid_i (inst_valid_i),
        .addr_i  (iaddr_i),
        .ref_i   (stop_addr_q),
        .match_o (stop_hit)
    );

    // A programmed count of zero behaves as one; the extra bit keeps the
    // increment from wrapping before the compare.
    assign hit_cnt_d = (CNT_W+1)'(hit_cnt_q) + (CNT_W+1)'(1);
    assign threshold = (start_count_q == '0) ? (CNT_W+1)'(1)
                                             : (CNT_W+1)'(start_count_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            trigger_q     <= TRIG_NONE;
            hit_cnt_q     <= '0;
            start_addr_q  <= '0;
            stop_addr_q   <= '0;
            start_count_q <= '0;
            oneshot_q     <= 1'b0;
        end else begin
            trigger_q <= TRIG_NONE;
            case (state_q)
                IDLE: begin
                    if (trig_enable_i) begin
                        start_addr_q  <= start_addr_i;
                        stop_addr_q   <= stop_addr_i;
                        start_count_q <= start_count_i;
                        oneshot_q     <= trig_oneshot_i;
                        hit_cnt_q     <= '0;
                        state_q       <= ARMED;
                    end
                end
                ARMED: begin
                    if (!trig_enable_i) begin
                        hit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (start_hit) begin
                        if (hit_cnt_d >= threshold) begin
                            trigger_q <= TRIG_TRACE_ON;
                            hit_cnt_q <= '0;
                            state_q   <= ACTIVE;
                        end else begin
                            hit_cnt_q <= hit_cnt_d[CNT_W-1:0];
                        end
                    end
                end
                ACTIVE: begin
                    // Disarming while tracing forces a trace-off so the filter
                    // is never left on.
                    if (!trig_enable_i) begin
                        trigger_q <= TRIG_TRACE_OFF;
                        state_q   <= IDLE;
                    end else if (stop_hit) begin
                        trigger_q <= TRIG_TRACE_OFF;
                        state_q   <= oneshot_q ? DONE : ARMED;
                    end
                end
                DONE: begin
                    if (!trig_enable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trigger_o   = trigger_q;
    assign state_o     = state_q;
    assign hit_count_o = hit_cnt_q;

endmodule
